// File: rtl/mac_pkg.sv
// Shared types and widths for the MAC dot-product sequencer and its operand FIFO.
package mac_pkg;

    localparam int OPW  = 4;
    localparam int ACCW = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        CAPT  = 3'd4,
        DONE  = 3'd5
    } seq_state_e;

    // An operand pair travels through the FIFO packed as {a, b}.
    function automatic logic [OPW-1:0] pair_a(input logic [2*OPW-1:0] p);
        return p[2*OPW-1:OPW];
    endfunction

    function automatic logic [OPW-1:0] pair_b(input logic [2*OPW-1:0] p);
        return p[OPW-1:0];
    endfunction

endpackage

// File: rtl/mac_operand_fifo.sv
// DEPTH-entry synchronous FIFO for packed operand pairs; head is visible on rdata
// while not empty. A write while full is taken only when a read frees the slot.
module mac_operand_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;
    logic             rd_en;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mac_dot_sequencer.sv
// Feeds LEN buffered operand pairs into an external 4-bit MAC and returns the 9-bit sum.
// Optional MAC_DOT_SEQ_OVF_EN adds res_ovf, flagging sums that wrapped past 511.
module mac_dot_sequencer
    import mac_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  in_a,
    input  logic [OPW-1:0]  in_b,
    output logic [OPW-1:0]  mac_i,
    output logic [OPW-1:0]  mac_j,
    output logic            mac_clr,
    input  logic [ACCW-1:0] mac_f,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [ACCW-1:0] res_data,
`ifdef MAC_DOT_SEQ_OVF_EN
    output logic            res_ovf,
`endif
    output logic            busy
);

    localparam int CNTW = (LEN > 1) ? $clog2(LEN) : 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and res_data holds steady while res_valid is 1.

    seq_state_e       state_q, state_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic [OPW-1:0]   mac_i_q, mac_i_d;
    logic [OPW-1:0]   mac_j_q, mac_j_d;
    logic             mac_clr_q, mac_clr_d;
    logic             res_valid_q, res_valid_d;
    logic [ACCW-1:0]  res_data_q, res_data_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [2*OPW-1:0] fifo_head;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign fifo_pop  = (state_q == FEED) && !fifo_empty;

    mac_operand_fifo #(
        .WIDTH (2*OPW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({in_a, in_b}),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mac_i_d     = '0;
        mac_j_d     = '0;
        mac_clr_d   = 1'b0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d   = CLEAR;
                    mac_clr_d = 1'b1;
                end
            end
            CLEAR: begin
                count_d = '0;
                state_d = FEED;
            end
            FEED: begin
                // An empty FIFO is a bubble: operands stay 0 so the MAC holds.
                if (fifo_pop) begin
                    mac_i_d = pair_a(fifo_head);
                    mac_j_d = pair_b(fifo_head);
                    count_d = count_q + CNTW'(1);
                    if (count_q == CNTW'(LEN - 1)) state_d = DRAIN;
                end
            end
            DRAIN: state_d = CAPT;
            CAPT: begin
                res_data_d  = mac_f;
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            mac_i_q     <= '0;
            mac_j_q     <= '0;
            mac_clr_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mac_i_q     <= mac_i_d;
            mac_j_q     <= mac_j_d;
            mac_clr_q   <= mac_clr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign mac_i     = mac_i_q;
    assign mac_j     = mac_j_q;
    assign mac_clr   = mac_clr_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign busy      = (state_q != IDLE);

`ifdef MAC_DOT_SEQ_OVF_EN
    localparam int SHW = ACCW + $clog2(LEN);

    logic [SHW-1:0]   shadow_q, shadow_d;
    logic             res_ovf_q, res_ovf_d;
    logic [2*OPW-1:0] pop_prod;

    // Full-width product of the popped pair, summed without wrap.
    assign pop_prod = pair_a(fifo_head) * pair_b(fifo_head);

    always_comb begin
        shadow_d  = shadow_q;
        res_ovf_d = res_ovf_q;
        if (state_q == CLEAR) shadow_d = '0;
        if (fifo_pop) shadow_d = shadow_q + SHW'(pop_prod);
        if (state_q == CAPT) res_ovf_d = (shadow_q > SHW'((1 << ACCW) - 1));
        if ((state_q == DONE) && res_ready) res_ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q  <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    assign res_ovf = res_ovf_q;
`endif

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer: behavioural MAC, pair/result reference queues, directed
// and random transactions. Build with MAC_DOT_SEQ_OVF_EN to also check res_ovf.
module tb_mac_dot_sequencer;

  localparam int LEN   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [3:0] mac_i;
  logic [3:0] mac_j;
  logic       mac_clr;
  logic [8:0] mac_f;
  logic       res_valid;
  logic       res_ready;
  logic [8:0] res_data;
  logic       busy;
`ifdef MAC_DOT_SEQ_OVF_EN
  logic       res_ovf;
`endif

  mac_dot_sequencer #(.LEN(LEN), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mac_i     (mac_i),
    .mac_j     (mac_j),
    .mac_clr   (mac_clr),
    .mac_f     (mac_f),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
`ifdef MAC_DOT_SEQ_OVF_EN
    .res_ovf   (res_ovf),
`endif
    .busy      (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // behavioural 4-bit MAC: clear on mac_clr, else accumulate i*j modulo 512
  logic [8:0] mac_acc;
  always @(posedge clk or posedge rst) begin
    if (rst) mac_acc <= '0;
    else if (mac_clr) mac_acc <= '0;
    else mac_acc <= mac_acc + ({5'd0, mac_i} * {5'd0, mac_j});
  end
  assign mac_f = mac_acc;

  // scoreboard
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] pair_q[$];
  logic [8:0] exp_q[$];
  logic       ovf_q[$];
  int         grp_sum = 0;
  int         grp_n   = 0;
  int         clr_cnt = 0;
  int         res_cnt = 0;
  logic [8:0] last_res = '0;
  logic       last_ovf = 1'b0;
  logic       seen_full = 1'b0;
  logic       prev_clr = 1'b0;
  logic       prev_hold = 1'b0;
  logic [8:0] prev_data = '0;
  logic       rr_rand = 1'b0;
  logic       rr_fix  = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // monitor: everything sampled on the falling edge
  initial begin
    logic [7:0] exp_pair;
    logic       exp_ovf;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (in_valid && in_ready) begin
          pair_q.push_back({in_a, in_b});
          grp_sum += int'(in_a) * int'(in_b);
          grp_n++;
          if (grp_n == LEN) begin
            exp_q.push_back(9'(grp_sum % 512));
            ovf_q.push_back(grp_sum > 511);
            grp_sum = 0;
            grp_n   = 0;
          end
        end
        if (in_valid && !in_ready) seen_full = 1'b1;
        if (mac_i != 4'd0 || mac_j != 4'd0) begin
          if (pair_q.size() == 0) begin
            check_eq("op_unexpected", {mac_i, mac_j}, 0);
          end else begin
            exp_pair = pair_q.pop_front();
            check_eq("op_order", {mac_i, mac_j}, exp_pair);
          end
        end
        if (mac_clr) begin
          clr_cnt++;
          check_eq("clr_while_res", res_valid, 0);
          check_eq("clr_width", prev_clr, 0);
        end
        if (res_valid && prev_hold) check_eq("res_stable", res_data, prev_data);
        if (res_valid && res_ready) begin
          res_cnt++;
          last_res = res_data;
          if (exp_q.size() == 0) begin
            check_eq("res_unexpected", res_valid, 0);
          end else begin
            check_eq("res_data", res_data, exp_q.pop_front());
            exp_ovf = ovf_q.pop_front();
`ifdef MAC_DOT_SEQ_OVF_EN
            last_ovf = res_ovf;
            check_eq("res_ovf", res_ovf, exp_ovf);
`else
            last_ovf = exp_ovf;
`endif
          end
        end
        prev_clr  = mac_clr;
        prev_hold = res_valid && !res_ready;
        prev_data = res_data;
      end else begin
        prev_clr  = 1'b0;
        prev_hold = 1'b0;
      end
    end
  end

  // res_ready driver
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      res_ready = rr_rand ? ($urandom_range(0, 2) != 0) : rr_fix;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic [3:0] a, input logic [3:0] b);
    int   tries = 0;
    logic acc   = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      tries++;
      if (!acc && tries > 300) begin
        check_eq("push_timeout", acc, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((exp_q.size() != 0 || busy) && c < 600) begin
      tick();
      c++;
    end
    check_eq("drain_timeout", (c < 600), 1);
  endtask

  task automatic wait_res_valid();
    int c = 0;
    while (!res_valid && c < 100) begin
      tick();
      c++;
    end
    check_eq("res_valid_timeout", res_valid, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check_eq({tag, "_in_ready"}, in_ready, 1);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_res_valid"}, res_valid, 0);
    check_eq({tag, "_res_data"}, res_data, 0);
    check_eq({tag, "_mac_ij"}, {mac_i, mac_j}, 0);
    check_eq({tag, "_mac_clr"}, mac_clr, 0);
`ifdef MAC_DOT_SEQ_OVF_EN
    check_eq({tag, "_res_ovf"}, res_ovf, 0);
`endif
  endtask

  task automatic send_ref4();
    send_pair(4'd1, 4'd2);
    send_pair(4'd3, 4'd4);
    send_pair(4'd5, 4'd6);
    send_pair(4'd7, 4'd8);
  endtask

  int         clr0;
  logic [8:0] held;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    repeat (2) @(posedge clk);
    check_reset_outputs("init");
    tick();
    rst = 1'b0;
    tick();

    // async reset in the middle of FEED discards the partial dot product
    send_pair(4'd9, 4'd9);
    send_pair(4'd8, 4'd7);
    repeat (4) tick();
    @(posedge clk);
    #3;
    rst = 1'b1;
    pair_q.delete();
    exp_q.delete();
    ovf_q.delete();
    grp_sum = 0;
    grp_n   = 0;
    check_reset_outputs("midfeed");
    tick();
    rst = 1'b0;
    tick();
    send_ref4();
    wait_drain();
    check_eq("after_reset_res", last_res, 100);

    // back-to-back reference pairs
    clr0 = clr_cnt;
    send_ref4();
    wait_drain();
    check_eq("b2b_res", last_res, 100);
    check_eq("b2b_clr_pulses", clr_cnt - clr0, 1);

    // 3-cycle gap after the second pair: operands must be 0 in the bubble
    clr0 = clr_cnt;
    send_pair(4'd1, 4'd2);
    send_pair(4'd3, 4'd4);
    repeat (3) begin
      @(posedge clk);
      #2;
      if (pair_q.size() == 0) check_eq("gap_ops", {mac_i, mac_j}, 0);
    end
    send_pair(4'd5, 4'd6);
    send_pair(4'd7, 4'd8);
    wait_drain();
    check_eq("gap_res", last_res, 100);
    check_eq("gap_clr_pulses", clr_cnt - clr0, 1);

    // wrap past 511
    repeat (LEN) send_pair(4'd15, 4'd15);
    wait_drain();
    check_eq("ovf_res", last_res, 388);
`ifdef MAC_DOT_SEQ_OVF_EN
    check_eq("ovf_flag", last_ovf, 1);
`endif

    // result backpressure, FIFO fills while DONE waits
    rr_fix = 1'b0;
    tick();
    send_pair(4'd2, 4'd5);
    send_pair(4'd3, 4'd3);
    send_pair(4'd4, 4'd1);
    send_pair(4'd6, 4'd2);
    wait_res_valid();
    held = res_data;
    check_eq("bp_value", held, 10 + 9 + 4 + 12);
    repeat (DEPTH) send_pair(4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)));
    @(negedge clk);
    check_eq("bp_fifo_full", in_ready, 0);
    clr0 = clr_cnt;
    repeat (5) tick();
    check_eq("bp_hold_data", res_data, held);
    check_eq("bp_hold_valid", res_valid, 1);
    check_eq("bp_no_clear", clr_cnt - clr0, 0);
    rr_fix = 1'b1;
    wait_drain();

    // continuous (2,3) stream keeps the FIFO full while FEED pops
    seen_full = 1'b0;
    repeat (3 * LEN) send_pair(4'd2, 4'd3);
    wait_drain();
    check_eq("stream_res", last_res, 24);
    check_eq("stream_full_seen", seen_full, 1);

    // random transactions, random gaps and random result backpressure
    rr_rand = 1'b1;
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < LEN; k++) begin
        send_pair(4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)));
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    wait_drain();
    rr_rand = 1'b0;
    repeat (3) tick();
    check_eq("final_queue_empty", exp_q.size(), 0);
    check_eq("final_pairs_empty", pair_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
